// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs in a small FIFO and feeds them one at a time to a gcd_calc core.
// Zero-operand jobs are answered locally; a core that never signals done is aborted after TIMEOUT cycles.
module gcd_job_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_p,
  output logic [WIDTH-1:0] gcd_q,
  input  logic [WIDTH-1:0] gcd_r,
  input  logic             gcd_done,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
  } pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t          state, state_nxt;
  pair_t           mem [DEPTH];
  pair_t           head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   tmo_cnt;
  logic            push, pop, launch, cap_zero, cap_core, cap_to, tmo_inc;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || (count != '0);

  // Storage carries no reset; emptiness is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{p: in_p, q: in_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    launch    = 1'b0;
    cap_zero  = 1'b0;
    cap_core  = 1'b0;
    cap_to    = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      IDLE: begin
        // Only pop when the result slot is free so capture never collides.
        if (count != '0 && !out_valid) begin
          pop = 1'b1;
          if (head.p == '0 || head.q == '0) begin
            cap_zero = 1'b1;
          end else begin
            launch    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (gcd_done) begin
          cap_core  = 1'b1;
          state_nxt = RELEASE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          cap_to    = 1'b1;
          state_nxt = RELEASE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      RELEASE: begin
        if (!gcd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tmo_cnt   <= '0;
      gcd_start <= 1'b0;
      gcd_p     <= '0;
      gcd_q     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (launch) begin
        gcd_p     <= head.p;
        gcd_q     <= head.q;
        gcd_start <= 1'b1;
        tmo_cnt   <= '0;
      end else if (cap_core || cap_to) begin
        gcd_start <= 1'b0;
      end
      if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);

      if (cap_zero) begin
        out_r     <= (head.p == '0) ? head.q : head.p;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (cap_core) begin
        out_r     <= gcd_r;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (cap_to) begin
        out_r     <= '0;
        out_err   <= 1'b1;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural gcd_calc core (fixed latency, optional hang).
module tb_gcd_job_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_p = '0;
  logic [W-1:0] in_q = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_r;
  logic         out_err;
  logic         gcd_start;
  logic [W-1:0] gcd_p, gcd_q;
  logic [W-1:0] gcd_r = '0;
  logic         gcd_done = 1'b0;
  logic         busy;

  bit           hang = 1'b0;
  int           lat = 0;
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] res_r [0:15];
  logic         res_e [0:15];
  int           res_n = 0;
  int           start_rises = 0;
  logic         start_prev = 1'b0;

  gcd_job_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err),
    .gcd_start(gcd_start), .gcd_p(gcd_p), .gcd_q(gcd_q), .gcd_r(gcd_r), .gcd_done(gcd_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Behavioural core: done rises 4 edges after start is seen, held while start stays high.
  always @(posedge clk) begin
    if (!gcd_start) begin
      gcd_done <= 1'b0;
      lat      <= 0;
    end else if (!gcd_done && !hang) begin
      if (lat == 3) begin
        gcd_done <= 1'b1;
        gcd_r    <= gcd_f(gcd_p, gcd_q);
      end else begin
        lat <= lat + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (out_valid && out_ready && res_n < 16) begin
      res_r[res_n] = out_r;
      res_e[res_n] = out_err;
      res_n++;
    end
    if (gcd_start && !start_prev) start_rises++;
    start_prev = gcd_start;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push_pair(input logic [W-1:0] p, input logic [W-1:0] q);
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_p = p; in_q = q;
    k = 0;
    while (!in_ready && k < 500) begin @(negedge clk); k++; end
    checks++;
    if (k >= 500) begin
      failures++;
      $display("FAIL push_wait: in_ready=0 for %0d cycles, required 1", k);
    end
    @(posedge clk);
  endtask

  task automatic push_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 400 && res_n < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int k = 0; k < 300 && (busy || out_valid); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    res_n = 0;
    start_rises = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_err, gcd_start, busy, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_ctrl: {vld,err,start,busy,rdy}=%b, required 00001",
               {out_valid, out_err, gcd_start, busy, in_ready});
    end
    checks++;
    if ({out_r, gcd_p, gcd_q} !== '0) begin
      failures++;
      $display("FAIL reset_data: r=%0d p=%0d q=%0d, required 0 0 0", out_r, gcd_p, gcd_q);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int k;
    out_ready = 1'b1; hang = 1'b0;
    settle();
    push_pair(6, 4);
    push_idle();
    @(posedge clk); #1;
    checks++;
    if ({gcd_start, gcd_p, gcd_q} !== {1'b1, 8'd6, 8'd4}) begin
      failures++;
      $display("FAIL single_launch: start=%b p=%0d q=%0d, required 1 6 4", gcd_start, gcd_p, gcd_q);
    end
    k = 0;
    while (gcd_done !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    checks++;
    if ({gcd_done, gcd_start} !== 2'b11) begin
      failures++;
      $display("FAIL single_hold: done=%b start=%b, required 1 1", gcd_done, gcd_start);
    end
    @(posedge clk); #1;
    checks++;
    if ({gcd_start, out_valid, out_err, out_r} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL single_result: start=%b vld=%b err=%b r=%0d, required 0 1 0 2",
               gcd_start, out_valid, out_err, out_r);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp4 [4];
    exp4 = '{8'd6, 8'd7, 8'd1, 8'd85};
    out_ready = 1'b1;
    settle();
    push_pair(12, 18);
    push_pair(35, 14);
    push_pair(17, 5);
    push_pair(255, 85);
    push_idle();
    wait_results(4);
    checks++;
    if (res_n !== 4) begin
      failures++;
      $display("FAIL stream_count: results=%0d, required 4", res_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({res_e[i], res_r[i]} !== {1'b0, exp4[i]}) begin
        failures++;
        $display("FAIL stream_res%0d: err=%b r=%0d, required 0 %0d", i, res_e[i], res_r[i], exp4[i]);
      end
    end
    checks++;
    if (start_rises !== 4) begin
      failures++;
      $display("FAIL stream_starts: start pulses=%0d, required 4", start_rises);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic [W-1:0] exp5 [5];
    exp5 = '{8'd3, 8'd2, 8'd7, 8'd5, 8'd4};
    out_ready = 1'b0;
    settle();
    push_pair(9, 6);
    push_pair(10, 4);
    push_pair(21, 14);
    push_pair(0, 5);
    push_pair(8, 12);
    push_idle();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b, required 0", in_ready);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, gcd_start, in_ready, out_r} !== {1'b1, 1'b0, 1'b0, 8'd3} || start_rises !== 1) begin
      failures++;
      $display("FAIL bp_stall: vld=%b start=%b rdy=%b r=%0d pulses=%0d, required 1 0 0 3 1",
               out_valid, gcd_start, in_ready, out_r, start_rises);
    end
    out_ready = 1'b1;
    wait_results(5);
    checks++;
    if (res_n !== 5) begin
      failures++;
      $display("FAIL bp_count: results=%0d, required 5", res_n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_e[i], res_r[i]} !== {1'b0, exp5[i]}) begin
        failures++;
        $display("FAIL bp_res%0d: err=%b r=%0d, required 0 %0d", i, res_e[i], res_r[i], exp5[i]);
      end
    end
    checks++;
    if (start_rises !== 4) begin
      failures++;
      $display("FAIL bp_starts: start pulses=%0d, required 4", start_rises);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp3 [3];
    exp3 = '{8'd9, 8'd7, 8'd0};
    out_ready = 1'b1;
    settle();
    push_pair(0, 9);
    push_idle();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_err, out_r} !== {1'b1, 1'b0, 8'd9}) begin
      failures++;
      $display("FAIL bypass_latency: vld=%b err=%b r=%0d, required 1 0 9", out_valid, out_err, out_r);
    end
    push_pair(7, 0);
    push_pair(0, 0);
    push_idle();
    wait_results(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({res_e[i], res_r[i]} !== {1'b0, exp3[i]}) begin
        failures++;
        $display("FAIL bypass_res%0d: err=%b r=%0d, required 0 %0d", i, res_e[i], res_r[i], exp3[i]);
      end
    end
    checks++;
    if (res_n !== 3 || start_rises !== 0) begin
      failures++;
      $display("FAIL bypass_core: results=%0d pulses=%0d, required 3 0", res_n, start_rises);
    end
  endtask

  task automatic test_timeout();
    int hi;
    out_ready = 1'b1; hang = 1'b1;
    settle();
    push_pair(6, 4);
    push_idle();
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (gcd_start) hi++;
      else break;
    end
    checks++;
    if (hi !== 16) begin
      failures++;
      $display("FAIL timeout_len: start high %0d cycles, required 16", hi);
    end
    checks++;
    if ({out_valid, out_err, out_r} !== {1'b1, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL timeout_result: vld=%b err=%b r=%0d, required 1 1 0", out_valid, out_err, out_r);
    end
    hang = 1'b0;
    settle();
    push_pair(6, 4);
    push_idle();
    wait_results(1);
    checks++;
    if ({res_e[0], res_r[0]} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL timeout_recover: err=%b r=%0d, required 0 2", res_e[0], res_r[0]);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; hang = 1'b1;
    settle();
    push_pair(6, 4);
    push_pair(3, 3);
    push_pair(5, 10);
    push_idle();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({gcd_start, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_pre: start=%b busy=%b, required 1 1", gcd_start, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({gcd_start, out_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async: start=%b vld=%b busy=%b, required 0 0 0", gcd_start, out_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hang = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_empty: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    res_n = 0;
    push_pair(6, 4);
    push_idle();
    wait_results(1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (res_n !== 1 || {res_e[0], res_r[0]} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL rstmid_job: results=%0d err=%b r=%0d, required 1 0 2", res_n, res_e[0], res_r[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_bypass();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
